// File: rtl/mult_scheduler.sv
// rtl/mult_scheduler.sv - frame-synchronous time-multiplexed signed Q1.(BITSIZE-1) multiplier
module mult_scheduler #(
    parameter int BITSIZE  = 16,
    parameter int CHANNELS = 4
) (
    input  logic                         bclk,
    input  logic                         reset_n,
    input  logic                         lrclk,
    input  logic [CHANNELS-1:0]          enable_mask,
    input  logic [CHANNELS*BITSIZE-1:0]  in1_bus,
    input  logic [CHANNELS*BITSIZE-1:0]  in2_bus,
    output logic [CHANNELS*BITSIZE-1:0]  out_bus,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic signed [BITSIZE-1:0] S_MAX = {1'b0, {(BITSIZE-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, LOAD, MUL, COMMIT} state_t;

    state_t                        state;
    logic [2:0]                    lr_sync;
    logic                          start;
    logic [CHANNELS*BITSIZE-1:0]   a_snap;
    logic [CHANNELS*BITSIZE-1:0]   b_snap;
    logic [CHANNELS*BITSIZE-1:0]   shadow;
    logic [CHANNELS*BITSIZE-1:0]   shadow_nxt;
    logic [CHANNELS-1:0]           mask_snap;
    logic [IW-1:0]                 idx;
    logic [IW-1:0]                 next_idx;
    logic                          next_found;
    logic [IW-1:0]                 first_idx;
    logic signed [BITSIZE-1:0]     op_a;
    logic signed [BITSIZE-1:0]     op_b;
    logic signed [2*BITSIZE-1:0]   prod;
    logic signed [BITSIZE-1:0]     prod_r;
    logic                          unused_prod_lsbs;

    // lr_sync[1:0] is the two-flop synchroniser, lr_sync[2] the edge-detect history
    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            lr_sync <= '0;
            start   <= 1'b0;
        end else begin
            lr_sync <= {lr_sync[1:0], lrclk};
            start   <= lr_sync[1] & ~lr_sync[2];
        end
    end

    assign op_a = a_snap[idx*BITSIZE +: BITSIZE];
    assign op_b = b_snap[idx*BITSIZE +: BITSIZE];
    assign prod = op_a * op_b;
    assign unused_prod_lsbs = ^prod[BITSIZE-2:0];

    // Only (-1.0)*(-1.0) overflows; the two top product bits then disagree
    always_comb begin
        prod_r = prod[2*BITSIZE-2 -: BITSIZE];
        if (prod[2*BITSIZE-1] ^ prod[2*BITSIZE-2]) begin
            prod_r = S_MAX;
        end
    end

    always_comb begin
        shadow_nxt = shadow;
        shadow_nxt[idx*BITSIZE +: BITSIZE] = prod_r;
    end

    always_comb begin
        next_idx   = idx;
        next_found = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (i > int'(idx) && mask_snap[i]) begin
                next_idx   = IW'(i);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        first_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (enable_mask[i]) begin
                first_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            a_snap    <= '0;
            b_snap    <= '0;
            mask_snap <= '0;
            shadow    <= '0;
            idx       <= '0;
            out_bus   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (start && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    a_snap    <= in1_bus;
                    b_snap    <= in2_bus;
                    mask_snap <= enable_mask;
                    shadow    <= '0;
                    idx       <= first_idx;
                    if (enable_mask == '0) begin
                        state     <= COMMIT;
                        out_bus   <= '0;
                        out_valid <= 1'b1;
                    end else begin
                        state <= MUL;
                    end
                end
                MUL: begin
                    shadow <= shadow_nxt;
                    if (next_found) begin
                        idx <= next_idx;
                    end else begin
                        // Results land on the bus as the FSM enters COMMIT so the pulse aligns with it
                        state     <= COMMIT;
                        out_bus   <= shadow_nxt;
                        out_valid <= 1'b1;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_scheduler.sv
// tb/tb_mult_scheduler.sv - self-checking bench for mult_scheduler
module tb_mult_scheduler;
    localparam int W = 16;
    localparam int N = 4;

    logic           bclk = 1'b0;
    logic           reset_n = 1'b0;
    logic           lrclk = 1'b0;
    logic [N-1:0]   enable_mask = '0;
    logic [N*W-1:0] in1_bus = '0;
    logic [N*W-1:0] in2_bus = '0;
    logic [N*W-1:0] out_bus;
    logic           out_valid;
    logic           busy;
    logic           overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mult_scheduler #(.BITSIZE(W), .CHANNELS(N)) dut (
        .bclk(bclk),
        .reset_n(reset_n),
        .lrclk(lrclk),
        .enable_mask(enable_mask),
        .in1_bus(in1_bus),
        .in2_bus(in2_bus),
        .out_bus(out_bus),
        .out_valid(out_valid),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 bclk = ~bclk;
    always @(posedge bclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_mul(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        longint p;
        longint r;
        p = longint'(a) * longint'(b);
        r = p >>> (W - 1);
        if (r > (longint'(1) <<< (W - 1)) - 1) r = (longint'(1) <<< (W - 1)) - 1;
        return r[W-1:0];
    endfunction

    // Model: a frame started at cycle S snapshots in S+1, runs E multiplies, commits at S+2+E
    logic [3:0]     m_lh = '0;
    logic           m_active = 1'b0;
    int             m_s = 0;
    int             m_c = 0;
    logic [N*W-1:0] m_res = '0;
    logic [N*W-1:0] exp_out = '0;
    logic           exp_valid = 1'b0;
    logic           exp_over = 1'b0;
    logic           m_busy = 1'b0;
    logic           m_st = 1'b0;
    int             m_e = 0;

    always @(negedge bclk) begin
        m_st = 1'b0;
        if (!reset_n) begin
            m_lh = '0; m_active = 1'b0; exp_out = '0; exp_valid = 1'b0;
            exp_over = 1'b0; m_busy = 1'b0;
        end else begin
            m_st = m_lh[2] & ~m_lh[3];
            exp_valid = 1'b0;
            if (m_active && cyc == m_s + 1) begin
                m_e = 0;
                for (int i = 0; i < N; i++) begin
                    if (enable_mask[i]) begin
                        m_res[i*W +: W] = ref_mul(in1_bus[i*W +: W], in2_bus[i*W +: W]);
                        m_e++;
                    end else begin
                        m_res[i*W +: W] = '0;
                    end
                end
                m_c = m_s + 2 + m_e;
            end
            m_busy = m_active && cyc >= m_s + 1 && cyc <= m_c;
            if (m_active && cyc == m_c) begin
                exp_out = m_res;
                exp_valid = 1'b1;
            end
        end
        check("out_bus", out_bus, exp_out);
        check("out_valid", out_valid, exp_valid);
        check("busy", busy, m_busy);
        check("overrun", overrun, exp_over);
        if (reset_n) begin
            if (m_st) begin
                if (m_active) exp_over = 1'b1;
                else begin m_active = 1'b1; m_s = cyc; m_c = cyc + 100000; end
            end
            if (m_active && cyc == m_c) m_active = 1'b0;
            m_lh = {m_lh[2:0], lrclk};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge bclk);
        #1;
    endtask

    task automatic set_ops(input logic [N-1:0] m, input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        enable_mask = m; in1_bus = a; in2_bus = b;
    endtask

    task automatic wait_valid(output int vc, output logic [N*W-1:0] vbus);
        vc = -1;
        vbus = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge bclk);
            if (out_valid === 1'b1) begin
                vc = cyc; vbus = out_bus;
                break;
            end
        end
        @(posedge bclk); #1;
    endtask

    task automatic frame_check(input string name, input int lat, input logic [N*W-1:0] exp);
        int k, vc;
        logic [N*W-1:0] vbus;
        k = cyc;
        lrclk = 1'b1; tick(2); lrclk = 1'b0;
        wait_valid(vc, vbus);
        check({name, "_lat"}, vc - k, lat);
        check({name, "_bus"}, vbus, exp);
        tick(3);
    endtask

    task automatic rand_inputs();
        if ($urandom_range(0, 9) < 3) begin
            enable_mask = N'($urandom);
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0: begin in1_bus[i*W +: W] = 16'h8000; in2_bus[i*W +: W] = 16'h8000; end
                    1: begin in1_bus[i*W +: W] = 16'h7FFF; in2_bus[i*W +: W] = W'($urandom); end
                    default: begin in1_bus[i*W +: W] = W'($urandom); in2_bus[i*W +: W] = W'($urandom); end
                endcase
            end
        end
    endtask

    localparam logic [N*W-1:0] A1 = {16'h7FFF, 16'h8000, 16'hC000, 16'h4000};
    localparam logic [N*W-1:0] B1 = {16'h7FFF, 16'h8000, 16'h4000, 16'h4000};
    localparam logic [N*W-1:0] R1 = {16'h7FFE, 16'h7FFF, 16'hE000, 16'h2000};
    localparam logic [N*W-1:0] Q4 = {4{16'h4000}};

    initial begin
        int k, vc;
        logic [N*W-1:0] vbus;

        for (int i = 0; i < 12; i++) begin
            lrclk = ~lrclk; in1_bus = {$urandom, $urandom}; in2_bus = {$urandom, $urandom};
            enable_mask = N'($urandom); tick(1);
        end
        check("rst_out_bus", out_bus, '0);
        check("rst_flags", {out_valid, busy, overrun}, 3'b000);
        lrclk = 1'b0; reset_n = 1'b1; tick(12);

        set_ops(4'b1111, A1, B1);
        frame_check("full", 9, R1);
        set_ops(4'b0101, Q4, Q4);
        frame_check("m0101", 7, {16'h0000, 16'h2000, 16'h0000, 16'h2000});
        set_ops(4'b0000, Q4, Q4);
        frame_check("m0000", 5, '0);

        set_ops(4'b0001, {48'h0, 16'h2000}, {48'h0, 16'h2000});
        k = cyc; lrclk = 1'b1; tick(2); lrclk = 1'b0; tick(3);
        in1_bus[15:0] = 16'h7FFF; in2_bus[15:0] = 16'h7FFF;
        wait_valid(vc, vbus);
        check("snap_lat", vc - k, 6);
        check("snap_bus", vbus, {48'h0, 16'h0800});
        tick(3);
        frame_check("snap_next", 6, {48'h0, 16'h7FFE});

        set_ops(4'b1111, A1, B1);
        k = cyc; lrclk = 1'b1; tick(2); lrclk = 1'b0; tick(2); lrclk = 1'b1; tick(2); lrclk = 1'b0;
        wait_valid(vc, vbus);
        check("ovr_lat", vc - k, 9);
        check("ovr_bus", vbus, R1);
        tick(10);
        check("ovr_sticky", overrun, 1'b1);
        set_ops(4'b0011, Q4, Q4);
        frame_check("post_ovr", 7, {32'h0, 16'h2000, 16'h2000});
        check("ovr_still", overrun, 1'b1);

        set_ops(4'b1111, {4{16'h1234}}, {4{16'h4321}});
        lrclk = 1'b1; tick(2); lrclk = 1'b0; tick(4);
        reset_n = 1'b0; #1;
        check("midrst_bus", out_bus, '0);
        check("midrst_flags", {out_valid, busy, overrun}, 3'b000);
        tick(3); reset_n = 1'b1; tick(3);
        set_ops(4'b1111, A1, B1);
        frame_check("after_rst", 9, R1);
        check("after_rst_ovr", overrun, 1'b0);

        for (int f = 0; f < 150; f++) begin
            int hi, lo;
            hi = $urandom_range(1, 6);
            lo = $urandom_range(1, 12);
            lrclk = 1'b1;
            repeat (hi) begin rand_inputs(); tick(1); end
            lrclk = 1'b0;
            repeat (lo) begin rand_inputs(); tick(1); end
            if ($urandom_range(0, 29) == 0) begin
                reset_n = 1'b0; tick(2); reset_n = 1'b1;
            end
        end
        tick(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
